// File: rtl/trigger_coincidence_x8.sv
// Eight-channel threshold/coincidence trigger: hit detect, stretch, popcount compare,
// then an ARMED/HOLDOFF trigger FSM, with per-channel saturating hit scalers.
module trigger_coincidence_x8 #(
    parameter int HOLDOFF_BITS = 16,
    parameter int SCALER_BITS  = 16
) (
    input  logic                         aclk,
    input  logic                         reset_i,
    input  logic [7:0][39:0]             dat_i,
    input  logic [7:0][4:0]              thr_i,
    input  logic [3:0]                   coinc_i,
    input  logic [3:0]                   stretch_i,
    input  logic [HOLDOFF_BITS-1:0]      holdoff_i,
    input  logic                         scaler_clr_i,
    output logic                         trig_o,
    output logic [7:0]                   trig_mask_o,
    output logic [7:0][SCALER_BITS-1:0]  scaler_o,
    output logic                         busy_o
);

    typedef enum logic {
        ARMED   = 1'b0,
        HOLDOFF = 1'b1
    } state_t;

    // Magnitude of a 5-bit two's complement sample; 6 bits so that |-16| = 16.
    function automatic logic [5:0] abs_mag(input logic [4:0] s);
        if (s[4]) begin
            return 6'd0 - {1'b1, s};
        end
        return {1'b0, s};
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: per-channel threshold compare over all eight samples
    // ------------------------------------------------------------------
    logic [7:0] hit_next;
    logic [7:0] hit;
    logic [7:0] hit_prev;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        hit_next = '0;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 8; k++) begin
                if ((thr_i[c] != 5'd0) &&
                    (abs_mag(dat_i[c][5*k +: 5]) >= {1'b0, thr_i[c]})) begin
                    hit_next[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            hit      <= '0;
            hit_prev <= '0;
        end else begin
            hit      <= hit_next;
            hit_prev <= hit;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: stretch counters; a hit reloads, so back-to-back hits never gap
    // ------------------------------------------------------------------
    logic [7:0][3:0] stretch_cnt;
    logic [7:0]      active;

    always_ff @(posedge aclk) begin
        if (reset_i) begin
            stretch_cnt <= '0;
            active      <= '0;
        end else begin
            for (int c = 0; c < 8; c++) begin
                if (hit[c]) begin
                    stretch_cnt[c] <= stretch_i;
                end else if (stretch_cnt[c] != 4'd0) begin
                    stretch_cnt[c] <= stretch_cnt[c] - 4'd1;
                end
                active[c] <= hit[c] | (stretch_cnt[c] != 4'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: popcount, with the matching active vector kept for the mask
    // ------------------------------------------------------------------
    logic [3:0] pop;
    logic [7:0] active_q;

    always_ff @(posedge aclk) begin
        if (reset_i) begin
            pop      <= '0;
            active_q <= '0;
        end else begin
            pop      <= popcount8(active);
            active_q <= active;
        end
    end

    // ------------------------------------------------------------------
    // Trigger FSM
    // ------------------------------------------------------------------
    state_t                  state;
    state_t                  state_next;
    logic [HOLDOFF_BITS-1:0] hold_cnt;
    logic [HOLDOFF_BITS-1:0] hold_next;
    logic                    trig_next;
    logic [7:0]              mask_next;

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        trig_next  = 1'b0;
        mask_next  = trig_mask_o;
        case (state)
            ARMED: begin
                if ((coinc_i != 4'd0) && (pop >= coinc_i)) begin
                    trig_next  = 1'b1;
                    mask_next  = active_q;
                    hold_next  = holdoff_i;
                    state_next = HOLDOFF;
                end
            end
            HOLDOFF: begin
                // Counting down to zero inclusive gives holdoff_i+1 dead cycles.
                if (hold_cnt == '0) begin
                    state_next = ARMED;
                end else begin
                    hold_next = hold_cnt - HOLDOFF_BITS'(1);
                end
            end
            default: state_next = ARMED;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset_i) begin
            state       <= ARMED;
            hold_cnt    <= '0;
            trig_o      <= 1'b0;
            trig_mask_o <= '0;
        end else begin
            state       <= state_next;
            hold_cnt    <= hold_next;
            trig_o      <= trig_next;
            trig_mask_o <= mask_next;
        end
    end

    assign busy_o = (state == HOLDOFF);

    // ------------------------------------------------------------------
    // Scalers: count rising edges of hit, saturating; clear has priority
    // ------------------------------------------------------------------
    logic [7:0] hit_rise;
    assign hit_rise = hit & ~hit_prev;

    always_ff @(posedge aclk) begin
        if (reset_i || scaler_clr_i) begin
            scaler_o <= '0;
        end else begin
            for (int c = 0; c < 8; c++) begin
                if (hit_rise[c] && (scaler_o[c] != '1)) begin
                    scaler_o[c] <= scaler_o[c] + SCALER_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_trigger_coincidence_x8.sv
// Directed bench for trigger_coincidence_x8: latency, stretch overlap, holdoff,
// channel masking, scaler saturation/clear and reset during holdoff.
module tb_trigger_coincidence_x8;

    localparam int HB = 16;
    localparam int SB = 8;

    logic                aclk = 1'b0;
    logic                reset_i;
    logic [7:0][39:0]    dat;
    logic [7:0][4:0]     thr;
    logic [3:0]          coinc;
    logic [3:0]          stretch;
    logic [HB-1:0]       holdoff;
    logic                scaler_clr;
    logic                trig;
    logic [7:0]          trig_mask;
    logic [7:0][SB-1:0]  scaler;
    logic                busy;

    int n_checks = 0;
    int n_pass   = 0;

    trigger_coincidence_x8 #(.HOLDOFF_BITS(HB), .SCALER_BITS(SB)) dut (
        .aclk        (aclk),
        .reset_i     (reset_i),
        .dat_i       (dat),
        .thr_i       (thr),
        .coinc_i     (coinc),
        .stretch_i   (stretch),
        .holdoff_i   (holdoff),
        .scaler_clr_i(scaler_clr),
        .trig_o      (trig),
        .trig_mask_o (trig_mask),
        .scaler_o    (scaler),
        .busy_o      (busy)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [39:0] mk_word(input int k, input logic [4:0] v);
        logic [39:0] w;
        w = '0;
        w[5*k +: 5] = v;
        return w;
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        dat = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        step();
        step();
        n_checks++; if (trig !== 1'b0) $display("FAIL reset_trig: got %b want 0", trig); else n_pass++;
        n_checks++; if (trig_mask !== 8'h00) $display("FAIL reset_mask: got %h want 00", trig_mask); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (scaler !== '0) $display("FAIL reset_scaler: got %h want 0", scaler); else n_pass++;
        reset_i = 1'b0;
    endtask

    task automatic test_latency();
        dat    = '0;
        dat[0] = mk_word(3, 5'd5);
        dat[1] = mk_word(7, 5'b11100);
        step();
        dat = '0;
        step();
        n_checks++; if (trig !== 1'b0) $display("FAIL lat_n1: got %b want 0", trig); else n_pass++;
        step();
        n_checks++; if (trig !== 1'b0) $display("FAIL lat_n2: got %b want 0", trig); else n_pass++;
        step();
        n_checks++; if (trig !== 1'b1) $display("FAIL lat_n3: got %b want 1", trig); else n_pass++;
        n_checks++; if (trig_mask !== 8'h03) $display("FAIL lat_mask: got %h want 03", trig_mask); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL lat_busy0: got %b want 1", busy); else n_pass++;
        for (int i = 1; i <= 10; i++) begin
            step();
            n_checks++;
            if (busy !== 1'b1 || trig !== 1'b0)
                $display("FAIL lat_hold[%0d]: got busy=%b trig=%b want busy=1 trig=0", i, busy, trig);
            else n_pass++;
        end
        step();
        n_checks++; if (busy !== 1'b0) $display("FAIL lat_busy_end: got %b want 0", busy); else n_pass++;
        n_checks++; if (scaler[0] !== 8'd1 || scaler[1] !== 8'd1)
            $display("FAIL lat_scaler: got %0d/%0d want 1/1", scaler[0], scaler[1]); else n_pass++;
    endtask

    task automatic test_below_threshold();
        int ntrig;
        ntrig  = 0;
        dat    = '0;
        dat[0] = mk_word(0, 5'd3);
        dat[1] = mk_word(2, 5'b11101);
        step();
        dat = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (trig) ntrig++;
        end
        n_checks++; if (ntrig != 0) $display("FAIL below_thr: got %0d triggers want 0", ntrig); else n_pass++;
    endtask

    task automatic test_stretch();
        int ntrig;
        coinc   = 4'd2;
        stretch = 4'd3;
        holdoff = 16'd2;
        idle(8);
        dat[2] = mk_word(0, 5'd6);
        step();
        dat = '0;
        step();
        step();
        dat[5] = mk_word(1, 5'd6);
        step();
        dat = '0;
        step();
        step();
        n_checks++; if (trig !== 1'b0) $display("FAIL stretch_e5: got %b want 0", trig); else n_pass++;
        step();
        n_checks++; if (trig !== 1'b1) $display("FAIL stretch_trig: got %b want 1", trig); else n_pass++;
        n_checks++; if (trig_mask !== 8'h24) $display("FAIL stretch_mask: got %h want 24", trig_mask); else n_pass++;
        idle(10);
        ntrig = 0;
        dat[2] = mk_word(0, 5'd6);
        step();
        dat = '0;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (trig) ntrig++;
        end
        dat[5] = mk_word(1, 5'd6);
        step();
        if (trig) ntrig++;
        dat = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (trig) ntrig++;
        end
        n_checks++; if (ntrig != 0) $display("FAIL stretch_gap: got %0d triggers want 0", ntrig); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic exp;
        coinc   = 4'd1;
        holdoff = '0;
        stretch = 4'd0;
        idle(8);
        dat[0] = mk_word(0, 5'd10);
        for (int i = 0; i < 12; i++) begin
            step();
            exp = (i >= 3) && (((i - 3) % 2) == 0);
            n_checks++;
            if (trig !== exp) $display("FAIL alt_trig[%0d]: got %b want %b", i, trig, exp);
            else n_pass++;
        end
        n_checks++; if (scaler[0] !== 8'd2) $display("FAIL alt_scaler0: got %0d want 2", scaler[0]); else n_pass++;
        idle(8);
    endtask

    task automatic test_masked_channel();
        int ntrig;
        logic [39:0] neg16;
        neg16 = '0;
        for (int k = 0; k < 8; k++) neg16[5*k +: 5] = 5'b10000;
        coinc   = 4'd1;
        holdoff = '0;
        thr[3]  = 5'd0;
        idle(4);
        ntrig  = 0;
        dat[3] = neg16;
        for (int i = 0; i < 10; i++) begin
            step();
            if (trig) ntrig++;
        end
        n_checks++; if (ntrig != 0) $display("FAIL mask_trig: got %0d triggers want 0", ntrig); else n_pass++;
        n_checks++; if (scaler[3] !== 8'd0) $display("FAIL mask_scaler3: got %0d want 0", scaler[3]); else n_pass++;
        thr[3] = 5'd16;
        ntrig  = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (trig) ntrig++;
        end
        n_checks++; if (ntrig != 2) $display("FAIL neg16_trig: got %0d triggers want 2", ntrig); else n_pass++;
        idle(2);
        n_checks++; if (scaler[3] !== 8'd1) $display("FAIL neg16_scaler3: got %0d want 1", scaler[3]); else n_pass++;
        thr[3] = 5'd4;
        idle(8);
    endtask

    task automatic test_scaler_saturate();
        int ntrig;
        coinc = 4'd0;
        idle(4);
        scaler_clr = 1'b1;
        step();
        scaler_clr = 1'b0;
        n_checks++; if (scaler !== '0) $display("FAIL clr_all: got %h want 0", scaler); else n_pass++;
        ntrig = 0;
        for (int i = 0; i < 300; i++) begin
            dat[4] = mk_word(i % 8, 5'd8);
            step();
            if (trig) ntrig++;
            dat[4] = '0;
            step();
            if (trig) ntrig++;
        end
        idle(2);
        n_checks++; if (scaler[4] !== 8'hFF) $display("FAIL sat_scaler4: got %h want ff", scaler[4]); else n_pass++;
        n_checks++; if (scaler[0] !== 8'd0) $display("FAIL sat_scaler0: got %h want 00", scaler[0]); else n_pass++;
        n_checks++; if (ntrig != 0) $display("FAIL coinc0_trig: got %0d triggers want 0", ntrig); else n_pass++;
        dat[4] = mk_word(0, 5'd8);
        step();
        scaler_clr = 1'b1;
        step();
        scaler_clr = 1'b0;
        n_checks++; if (scaler[4] !== 8'd0) $display("FAIL clr_vs_rise: got %h want 00", scaler[4]); else n_pass++;
        step();
        n_checks++; if (scaler[4] !== 8'd0) $display("FAIL clr_hold: got %h want 00", scaler[4]); else n_pass++;
        idle(4);
    endtask

    task automatic test_reset_in_holdoff();
        int waited;
        coinc   = 4'd2;
        stretch = 4'd0;
        holdoff = 16'd100;
        idle(4);
        dat[0] = mk_word(3, 5'd5);
        dat[1] = mk_word(7, 5'b11100);
        waited = 0;
        do begin
            step();
            waited++;
        end while (trig !== 1'b1 && waited < 10);
        n_checks++; if (waited != 4) $display("FAIL rh_first_trig: got edge %0d want 4", waited); else n_pass++;
        for (int i = 0; i < 5; i++) step();
        n_checks++; if (busy !== 1'b1) $display("FAIL rh_busy_mid: got %b want 1", busy); else n_pass++;
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL rh_busy_reset: got %b want 0", busy); else n_pass++;
        n_checks++; if (trig_mask !== 8'h00) $display("FAIL rh_mask_reset: got %h want 00", trig_mask); else n_pass++;
        step();
        step();
        step();
        n_checks++; if (trig !== 1'b0) $display("FAIL rh_no_stale: got %b want 0", trig); else n_pass++;
        step();
        n_checks++; if (trig !== 1'b1) $display("FAIL rh_retrig: got %b want 1", trig); else n_pass++;
        n_checks++; if (trig_mask !== 8'h03) $display("FAIL rh_retrig_mask: got %h want 03", trig_mask); else n_pass++;
        idle(2);
    endtask

    initial begin
        reset_i    = 1'b1;
        dat        = '0;
        for (int c = 0; c < 8; c++) thr[c] = 5'd4;
        coinc      = 4'd2;
        stretch    = 4'd0;
        holdoff    = 16'd10;
        scaler_clr = 1'b0;

        test_reset();
        test_latency();
        test_below_threshold();
        test_stretch();
        test_back_to_back();
        test_masked_channel();
        test_scaler_saturate();
        test_reset_in_holdoff();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/trigger_coincidence_x8.md
TRIGGER_COINCIDENCE_X8 -- requirements
Module: trigger_coincidence_x8

Interface
REQ-001 Parameter HOLDOFF_BITS, default 16, width of the holdoff count.
REQ-002 Parameter SCALER_BITS, default 16, width of each per-channel scaler.
REQ-003 Port aclk, input, 1, sole clock; all logic SHALL be synchronous to its rising edge.
REQ-004 Port reset_i, input, 1, synchronous active-high reset.
REQ-005 Port dat_i, input, [7:0][39:0], per-channel AGC output: 8 samples x 5-bit two's complement, sample k in bits [5k+4:5k], one word per clock, no valid qualifier.
REQ-006 Port thr_i, input, [7:0][4:0], per-channel unsigned magnitude threshold; 0 masks the channel.
REQ-007 Port coinc_i, input, 4, number of active channels required to trigger; 0 disables triggering.
REQ-008 Port stretch_i, input, 4, extra cycles a channel stays active after its last hit.
REQ-009 Port holdoff_i, input, HOLDOFF_BITS, dead-time control after a trigger.
REQ-010 Port scaler_clr_i, input, 1, synchronous clear of all scalers.
REQ-011 Port trig_o, output, 1, single-cycle trigger pulse.
REQ-012 Port trig_mask_o, output, 8, channels active in the cycle trig_o asserted; held until the next trigger.
REQ-013 Port scaler_o, output, [7:0][SCALER_BITS-1:0], per-channel hit counts.
REQ-014 Port busy_o, output, 1, high while in HOLDOFF.

Function
REQ-015 Stage 1: hit[c] SHALL be registered high when thr_i[c] != 0 and |sample| >= thr_i[c] for any of the 8 samples; |-16| = 16, using 6-bit unsigned magnitude.
REQ-016 Stage 2: per-channel 4-bit stretch counter; on hit[c] it loads stretch_i, otherwise it decrements to 0 and stops there; active[c] = hit[c] OR counter != 0.
REQ-017 A hit while the counter is nonzero SHALL reload it, with no gap in active[c].
REQ-018 Stage 3: a registered popcount of active[7:0] (0..8) is compared against coinc_i.
REQ-019 FSM states ARMED and HOLDOFF; reset enters ARMED.
REQ-020 In ARMED with coinc_i != 0 and popcount >= coinc_i, trig_o SHALL pulse one cycle, trig_mask_o SHALL load active[7:0] from the same compare, the holdoff counter SHALL load holdoff_i, and the state SHALL go to HOLDOFF.
REQ-021 Latency: a dat_i word at edge N that completes coincidence SHALL produce trig_o high after edge N+3.
REQ-022 HOLDOFF SHALL last holdoff_i+1 cycles, counting the value captured at trigger time; holdoff_i = 0 gives one dead cycle, then ARMED.
REQ-023 Coincidences during HOLDOFF SHALL be ignored, not queued; hits and stretch counters SHALL keep running.
REQ-024 thr_i, coinc_i and stretch_i changes SHALL take effect at their pipeline stage on the next edge, with no flush.
REQ-025 scaler[c] SHALL increment on each 0->1 edge of hit[c] and saturate at all-ones.
REQ-026 scaler_clr_i SHALL zero all scalers; clear SHALL win over a simultaneous increment.
REQ-027 Scalers SHALL count regardless of FSM state.

Reset
REQ-028 reset_i SHALL zero trig_o, trig_mask_o, scaler_o, busy_o, all hit, stretch, popcount and holdoff registers, and force ARMED, mid-HOLDOFF included.
REQ-029 The first trigger after reset release SHALL need a fresh coincidence through all 3 stages; no stale pipeline data.

Verification
REQ-030 thr=4 on all channels, coinc=2, stretch=0, holdoff=10; ch0 sample3=+5 and ch1 sample7=-4 at edge N -> trig_o only after edge N+3, trig_mask_o=8'h03, busy_o high 11 cycles.
REQ-031 coinc=2, stretch=3; ch2 hit at cycle 0, ch5 hit at cycle 3 -> trigger with mask 8'h24; ch5 hit at cycle 5 -> no trigger.
REQ-032 coinc=1, holdoff=0; ch0 over threshold every cycle -> trig_o on alternate cycles.
REQ-033 thr[3]=0; ch3 samples -16 continuously -> no hit, scaler[3]=0, no trigger.
REQ-034 ch4 toggles above and below threshold 70000 times -> scaler[4]=16'hFFFF; scaler_clr_i together with a rising hit -> 0.
REQ-035 reset_i at holdoff cycle 5 of 100 with coincidence held -> busy_o=0 on the next edge and trig_o again 3 cycles after reset release.
